operand_stage_nw: RTL

//  Parametrised N-lane operand-fetch stage between decoder and execute. Latches each lane's decoded

---
 rtl/operand_pkg.sv | 52 +++++
 rtl/regfile_nrnw.sv | 47 ++++
 rtl/operand_stage_nw.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared types, widths and forwarding select for the operand stage
package operand_pkg;

  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int MAX_WB    = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rd_type;
    logic [4:0]  rd;
    logic [7:0]  h_exe_unit;
    logic [11:0] func_code;
    logic [2:0]  func3;
    logic [1:0]  func2;
    logic        endsim;
    logic        auipc;
  } lane_payload_t;

  localparam int PAYLOAD_W = $bits(lane_payload_t);

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      value;
  } wb_req_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } fwd_sel_t;

  // Highest-index matching writeback wins; x0 never hits so it always reads as zero.
  function automatic fwd_sel_t fwd_select(
    input logic [MAX_WB-1:0]                valid,
    input logic [MAX_WB-1:0][REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0]             r
  );
    fwd_sel_t sel;
    sel = '0;
    for (int p = 0; p < MAX_WB; p++) begin
      if (valid[p] && (rd[p] == r) && (r != '0)) begin
        sel.hit  = 1'b1;
        sel.port = p[1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_nrnw.sv
// rtl/regfile_nrnw.sv - multi-port integer regfile, async read, sync write, x0 hardwired to zero
module regfile_nrnw
  import operand_pkg::*;
#(
  parameter int RD_PORTS = 6,
  parameter int WR_PORTS = 2,
  parameter int XLEN     = 64,
  parameter int NREGS    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_addr,
  output logic [RD_PORTS*XLEN-1:0]      rd_data,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*REG_IDX_W-1:0] wr_addr,
  input  logic [WR_PORTS*XLEN-1:0]      wr_data
);

  logic [XLEN-1:0] mem [NREGS];

  // Later ports overwrite earlier ones in the loop, matching the forwarding priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[p*REG_IDX_W +: REG_IDX_W] != '0) &&
            (32'(wr_addr[p*REG_IDX_W +: REG_IDX_W]) < NREGS)) begin
          mem[wr_addr[p*REG_IDX_W +: REG_IDX_W]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if ((rd_addr[p*REG_IDX_W +: REG_IDX_W] != '0) &&
          (32'(rd_addr[p*REG_IDX_W +: REG_IDX_W]) < NREGS)) begin
        rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*REG_IDX_W +: REG_IDX_W]];
      end
    end
  end

endmodule

// File: rtl/operand_stage_nw.sv
// rtl/operand_stage_nw.sv - N-lane operand fetch with writeback forwarding and stall refresh
module operand_stage_nw
  import operand_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int WB_PORTS  = 2,
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int SID_W     = 5,
  parameter int PAYLOAD_W = 129
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [LANES-1:0]                 stall_i,
  input  logic [LANES-1:0]                 dec_valid_i,
  input  logic [LANES*PAYLOAD_W-1:0]       dec_payload_i,
  input  logic [LANES*3-1:0]               dec_rs_valid_i,
  input  logic [LANES*3*REG_IDX_W-1:0]     dec_rs_i,
  input  logic [LANES*SID_W-1:0]           dec_sid_i,
  input  logic [WB_PORTS-1:0]              wb_valid_i,
  input  logic [WB_PORTS*REG_IDX_W-1:0]    wb_rd_i,
  input  logic [WB_PORTS*XLEN-1:0]         wb_value_i,
  output logic [LANES-1:0]                 op_valid_o,
  output logic [LANES*PAYLOAD_W-1:0]       op_payload_o,
  output logic [LANES*3-1:0]               op_rs_valid_o,
  output logic [LANES*3*REG_IDX_W-1:0]     op_rs_o,
  output logic [LANES*3*XLEN-1:0]          op_rs_value_o,
  output logic [LANES*SID_W-1:0]           op_sid_o
);

  localparam int RD_PORTS = LANES * 3;

  logic [RD_PORTS*XLEN-1:0] rd_data;

  regfile_nrnw #(
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WB_PORTS),
    .XLEN     (XLEN),
    .NREGS    (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (dec_rs_i),
    .rd_data (rd_data),
    .wr_en   (wb_valid_i),
    .wr_addr (wb_rd_i),
    .wr_data (wb_value_i)
  );

  // Pad writeback ports to the package maximum so one select function serves any WB_PORTS.
  logic [MAX_WB-1:0]                wb_valid_pad;
  logic [MAX_WB-1:0][REG_IDX_W-1:0] wb_rd_pad;
  logic [MAX_WB-1:0][XLEN-1:0]      wb_value_pad;

  always_comb begin
    wb_valid_pad = '0;
    wb_rd_pad    = '0;
    wb_value_pad = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_valid_pad[p] = wb_valid_i[p];
      wb_rd_pad[p]    = wb_rd_i[p*REG_IDX_W +: REG_IDX_W];
      wb_value_pad[p] = wb_value_i[p*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        for (int q = p + 1; q < WB_PORTS; q++) begin
          assert (!(wb_valid_i[p] && wb_valid_i[q] &&
                    (wb_rd_i[p*REG_IDX_W +: REG_IDX_W] == wb_rd_i[q*REG_IDX_W +: REG_IDX_W]) &&
                    (wb_rd_i[p*REG_IDX_W +: REG_IDX_W] != '0)))
            else $warning("writeback ports %0d and %0d collide on x%0d", p, q,
                          wb_rd_i[p*REG_IDX_W +: REG_IDX_W]);
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic                             valid;
    logic [PAYLOAD_W-1:0]             payload;
    logic [2:0]                       rs_valid;
    logic [2:0][REG_IDX_W-1:0]        rs;
    logic [2:0][XLEN-1:0]             value;
    logic [SID_W-1:0]                 sid;
    logic [2:0][XLEN-1:0]             load_value;
    logic [2:0][XLEN-1:0]             held_value;
    fwd_sel_t [2:0]                   dec_sel;
    fwd_sel_t [2:0]                   held_sel;

    always_comb begin
      dec_sel    = '0;
      held_sel   = '0;
      load_value = '0;
      held_value = value;
      for (int k = 0; k < 3; k++) begin
        dec_sel[k]  = fwd_select(wb_valid_pad, wb_rd_pad,
                                 dec_rs_i[(l*3+k)*REG_IDX_W +: REG_IDX_W]);
        held_sel[k] = fwd_select(wb_valid_pad, wb_rd_pad, rs[k]);
        if (dec_sel[k].hit) begin
          load_value[k] = wb_value_pad[dec_sel[k].port];
        end else begin
          load_value[k] = rd_data[(l*3+k)*XLEN +: XLEN];
        end
        // A held operand only tracks writebacks while it is live and actually used.
        if (valid && rs_valid[k] && held_sel[k].hit) begin
          held_value[k] = wb_value_pad[held_sel[k].port];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid    <= 1'b0;
        payload  <= '0;
        rs_valid <= '0;
        rs       <= '0;
        value    <= '0;
        sid      <= '0;
      end else if (flush_i) begin
        valid <= 1'b0;
      end else if (stall_i[l]) begin
        value <= held_value;
      end else begin
        valid    <= dec_valid_i[l];
        payload  <= dec_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
        rs_valid <= dec_rs_valid_i[l*3 +: 3];
        rs       <= dec_rs_i[l*3*REG_IDX_W +: 3*REG_IDX_W];
        value    <= load_value;
        sid      <= dec_sid_i[l*SID_W +: SID_W];
      end
    end

    assign op_valid_o[l]                                  = valid;
    assign op_payload_o[l*PAYLOAD_W +: PAYLOAD_W]         = payload;
    assign op_rs_valid_o[l*3 +: 3]                        = rs_valid;
    assign op_rs_o[l*3*REG_IDX_W +: 3*REG_IDX_W]          = rs;
    assign op_rs_value_o[l*3*XLEN +: 3*XLEN]              = value;
    assign op_sid_o[l*SID_W +: SID_W]                     = sid;
  end

endmodule
